// File: rtl/prores_enc_pkg.sv
// Shared definitions for the ProRes encoder entropy paths: scan order,
// AC position range, coder pipeline depth and scheduler states.
package prores_enc_pkg;

  localparam int unsigned AC_POS_FIRST     = 1;
  localparam int unsigned AC_POS_LAST      = 63;
  localparam int unsigned DRAIN_CYCLES_DEF = 5;

  // Progressive-frame scan order: scan position -> raster index in the 8x8 block.
  localparam logic [5:0] SCAN_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/prores_scan_rom.sv
// Combinational scan-order lookup, shared by the DC and AC paths.
module prores_scan_rom
  import prores_enc_pkg::*;
(
  input  logic [5:0] i_pos,
  output logic [5:0] o_scan
);

  // Pure table lookup.
  always_comb begin
    o_scan = SCAN_TABLE[i_pos];
  end

endmodule

// File: rtl/entropy_encode_ac_scheduler.sv
// Sequences one slice through the AC run/level coders: clears the coders,
// streams coefficients in ProRes AC order (position-major, block-minor),
// waits for the coder pipeline to drain, then pulses done.
module entropy_encode_ac_scheduler
  import prores_enc_pkg::*;
#(
  parameter int unsigned MAX_BLOCKS   = 32,
  parameter int unsigned COEFF_W      = 32,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned ADDR_W       = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [5:0]         block_num,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [COEFF_W-1:0] rd_data,
  output logic [COEFF_W-1:0] coeff_out,
  output logic               coeff_valid,
  output logic               coeff_last,
  output logic               coder_rst_n
);

  localparam int unsigned BLK_W  = ADDR_W - 6;
  localparam int unsigned DCNT_W = (DRAIN_CYCLES < 8) ? 3 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [5:0]  N_MAX     = 6'(MAX_BLOCKS);
  localparam logic [5:0]  POS_FIRST = 6'(AC_POS_FIRST);
  localparam logic [5:0]  POS_LAST  = 6'(AC_POS_LAST);

  state_e              r_state;
  state_e              w_state_next;
  logic [5:0]          r_pos;
  logic [BLK_W-1:0]    r_blk;
  logic [5:0]          r_n;
  logic                r_empty;
  logic [DCNT_W-1:0]   r_drain;
  logic                r_rd_vld;
  logic                r_rd_last;
  logic [5:0]          w_scan;
  logic [5:0]          w_n_clamped;
  logic                w_blk_wrap;
  logic                w_last_issue;

  prores_scan_rom u_scan_rom (
    .i_pos  (r_pos),
    .o_scan (w_scan)
  );

  // Block-loop wrap, final-read detection and block-count clamp.
  always_comb begin
    w_blk_wrap   = (r_blk == BLK_W'(r_n - 6'd1));
    w_last_issue = (r_state == ISSUE) && w_blk_wrap && (r_pos == POS_LAST);
    w_n_clamped  = (block_num > N_MAX) ? N_MAX : block_num;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode and state-derived outputs.
  // An empty slice passes through WAIT so that busy covers exactly one cycle
  // before done; r_empty then routes WAIT straight to DONE, skipping DRAIN.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = (block_num == '0) ? WAIT : CLEAR;
      end
      CLEAR: begin
        busy         = 1'b1;
        w_state_next = ISSUE;
      end
      ISSUE: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = ADDR_W'({r_blk, w_scan});
        if (w_last_issue) w_state_next = WAIT;
      end
      WAIT: begin
        busy         = 1'b1;
        w_state_next = r_empty ? DONE : DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drain == DCNT_W'(DRAIN_CYCLES)) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Slice parameters, scan/block counters and drain counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pos   <= '0;
      r_blk   <= '0;
      r_n     <= '0;
      r_empty <= 1'b0;
      r_drain <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_n     <= w_n_clamped;
            r_empty <= (block_num == '0);
            r_pos   <= POS_FIRST;
            r_blk   <= '0;
          end
        end
        ISSUE: begin
          if (w_blk_wrap) begin
            r_blk <= '0;
            r_pos <= r_pos + 6'd1;
          end else begin
            r_blk <= r_blk + BLK_W'(1);
          end
        end
        WAIT:    r_drain <= '0;
        DRAIN:   r_drain <= r_drain + DCNT_W'(1);
        default: ;
      endcase
    end
  end

  // Read-return alignment and the single output stage to the coders.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      coeff_out   <= '0;
      coeff_valid <= 1'b0;
      coeff_last  <= 1'b0;
      coder_rst_n <= 1'b0;
    end else begin
      r_rd_vld    <= rd_en;
      r_rd_last   <= w_last_issue;
      coeff_out   <= r_rd_vld ? rd_data : '0;
      coeff_valid <= r_rd_vld;
      coeff_last  <= r_rd_last;
      coder_rst_n <= (w_state_next != CLEAR);
    end
  end

endmodule
